// File: rtl/ecc_enc_dec_if.sv
// rtl/ecc_enc_dec_if.sv - start/config/result bundle between the register block and ecc_enc_dec.
// ECC_SYNDROME_OUT_EN adds the syndrome signal.
interface ecc_enc_dec_if #(
  parameter int AMBA_WORD  = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [AMBA_WORD-1:0]  CTRL;
  logic [AMBA_WORD-1:0]  DATA_IN;
  logic [AMBA_WORD-1:0]  CODEWORD_WIDTH;
  logic [AMBA_WORD-1:0]  NOISE;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  operation_done;
  logic [1:0]            num_of_errors;
`ifdef ECC_SYNDROME_OUT_EN
  logic [4:0]            syndrome;

  modport master (
    output start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
    input  data_out, operation_done, num_of_errors, syndrome
  );

  modport slave (
    input  start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
    output data_out, operation_done, num_of_errors, syndrome
  );
`else
  modport master (
    output start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
    input  data_out, operation_done, num_of_errors
  );

  modport slave (
    input  start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
    output data_out, operation_done, num_of_errors
  );
`endif
endinterface

// File: rtl/ecc_enc_dec.sv
// rtl/ecc_enc_dec.sv - extended-Hamming SEC-DED encode / decode / full-channel core.
// Defining ECC_SYNDROME_OUT_EN exposes the last decode syndrome on bus.syndrome.
module ecc_enc_dec #(
  parameter int AMBA_WORD  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  ecc_enc_dec_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ENC  = 3'd1;
  localparam logic [2:0] S_ADDN = 3'd2;
  localparam logic [2:0] S_DEC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_FULL = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef struct packed {
    logic [25:0] data;
    logic [4:0]  syn;
    logic [1:0]  nerr;
  } dec_t;

  function automatic logic [31:0] n_mask(input logic [1:0] w);
    case (w)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [25:0] k_mask(input logic [1:0] w);
    case (w)
      2'b00:   return 26'h000_000F;
      2'b01:   return 26'h000_07FF;
      default: return 26'h3FF_FFFF;
    endcase
  endfunction

  // The data-bit placement is the same for every n, so a full 32-bit code of
  // k-masked data already leaves positions >= n at zero.
  function automatic logic [31:0] ham_encode(input logic [25:0] d);
    logic [31:0] c;
    logic        par;
    int          j;
    c = '0;
    j = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      par = 1'b0;
      for (int p = 1; p < 32; p++) begin
        if (p[i]) par = par ^ c[p];
      end
      c[1 << i] = par;
    end
    c[0] = ^c[31:1];
    return c;
  endfunction

  function automatic dec_t ham_decode(input logic [31:0] cw);
    logic [31:0] c;
    logic [4:0]  s;
    dec_t        r;
    int          j;
    c = cw;
    s = '0;
    for (int p = 1; p < 32; p++) begin
      if (c[p]) s = s ^ 5'(p);
    end
    r.nerr = 2'd0;
    if (^c) begin
      c[s]   = ~c[s];
      r.nerr = 2'd1;
    end else if (s != 5'd0) begin
      r.nerr = 2'd2;
    end
    r.data = '0;
    j = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        r.data[j] = c[p];
        j++;
      end
    end
    r.syn = s;
    return r;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [25:0]           data_q, data_d;
  logic [31:0]           noise_q, noise_d;
  logic [31:0]           cw_q, cw_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [1:0]            nerr_q, nerr_d;
`ifdef ECC_SYNDROME_OUT_EN
  logic [4:0]            syn_q, syn_d;
`endif

  logic [1:0]  in_wsel;
  logic [1:0]  in_op;
  logic [31:0] in_nmask;
  logic [25:0] in_kmask;
  logic [31:0] enc_word;
  dec_t        dec_res;

  assign in_wsel  = bus.CODEWORD_WIDTH[1:0];
  assign in_op    = bus.CTRL[1:0];
  assign in_nmask = n_mask(in_wsel);
  assign in_kmask = k_mask(in_wsel);
  assign enc_word = ham_encode(data_q);
  assign dec_res  = ham_decode(cw_q);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    noise_d    = noise_q;
    cw_d       = cw_q;
    data_out_d = data_out_q;
    nerr_d     = nerr_q;
`ifdef ECC_SYNDROME_OUT_EN
    syn_d      = syn_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = in_op;
          data_d  = bus.DATA_IN[25:0] & in_kmask;
          noise_d = bus.NOISE[31:0] & in_nmask;
          cw_d    = bus.DATA_IN[31:0] & in_nmask;
          // No-op spends its middle cycle in DEC so it completes with encode/decode timing.
          if (in_op == OP_DEC || in_op == OP_NOP) state_d = S_DEC;
          else                                    state_d = S_ENC;
        end
      end
      S_ENC: begin
        cw_d = enc_word;
        if (op_q == OP_FULL) begin
          state_d = S_ADDN;
        end else begin
          state_d    = S_DONE;
          data_out_d = DATA_WIDTH'(enc_word);
          nerr_d     = 2'd0;
`ifdef ECC_SYNDROME_OUT_EN
          syn_d      = 5'd0;
`endif
        end
      end
      S_ADDN: begin
        cw_d    = cw_q ^ noise_q;
        state_d = S_DEC;
      end
      S_DEC: begin
        state_d = S_DONE;
        if (op_q == OP_NOP) begin
          data_out_d = '0;
          nerr_d     = 2'd0;
`ifdef ECC_SYNDROME_OUT_EN
          syn_d      = 5'd0;
`endif
        end else begin
          data_out_d = DATA_WIDTH'({6'd0, dec_res.data});
          nerr_d     = dec_res.nerr;
`ifdef ECC_SYNDROME_OUT_EN
          syn_d      = dec_res.syn;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ENC;
      data_q     <= '0;
      noise_q    <= '0;
      cw_q       <= '0;
      data_out_q <= '0;
      nerr_q     <= '0;
`ifdef ECC_SYNDROME_OUT_EN
      syn_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      noise_q    <= noise_d;
      cw_q       <= cw_d;
      data_out_q <= data_out_d;
      nerr_q     <= nerr_d;
`ifdef ECC_SYNDROME_OUT_EN
      syn_q      <= syn_d;
`endif
    end
  end

  assign bus.data_out       = data_out_q;
  assign bus.num_of_errors  = nerr_q;
  assign bus.operation_done = (state_q == S_DONE);

  logic unused_bits;
`ifdef ECC_SYNDROME_OUT_EN
  assign bus.syndrome = syn_q;
  assign unused_bits  = ^{bus.CTRL[AMBA_WORD-1:2], bus.CODEWORD_WIDTH[AMBA_WORD-1:2],
                          bus.DATA_IN, bus.NOISE};
`else
  assign unused_bits  = ^{bus.CTRL[AMBA_WORD-1:2], bus.CODEWORD_WIDTH[AMBA_WORD-1:2],
                          bus.DATA_IN, bus.NOISE, dec_res.syn};
`endif

endmodule
